dout_frame_capture: RTL and testbench
=====================================

Name: dout_frame_capture

Overview:
- Chip-side capture stage between the 10 MHz clock/CONV generator and the 64-in/32-out async FIFO.
- Each CONV rising edge starts one readout: requests transmission via DXMIT_BAR, shifts the serial DOUT stream while DVALID_BAR is low, and packs two samples plus frame metadata into one 64-bit FIFO word.
- Also computes the FIFO fill flag used for host triggering and records error conditions as sticky bits.

Parameters:
- SAMPLE_W, 20, bits per channel sample; legal range 1..20; MSB first on the wire.
- NCH, 2, samples per frame; only 2 is supported by the word format.
- TIMEOUT, 4096, SYS_CLK cycles without a valid bit before the readout aborts.
- CNT_W, 10, width of the FIFO write-count input and the threshold.

Ports:
- SYS_CLK in 1: 10 MHz capture clock. Single clock domain.
- RST in 1: reset, asynchronous, active-high.
- CONV in 1: conversion strobe from the clock generator; a rising edge starts a frame.
- DVALID_BAR in 1: low marks DOUT as valid this cycle.
- DOUT in 1: serial sample data.
- DXMIT_BAR out 1: low requests the chip to transmit.
- wr_en out 1: one-cycle FIFO write strobe.
- data2pipe out 64: packed frame word.
- fifo_full in 1: FIFO full, in the write domain.
- fifo_wr_cnt in CNT_W: FIFO write-side data count.
- fifo_th in CNT_W: fill threshold; 0 disables the flag.
- fifo_flag out 1: registered; high when fifo_wr_cnt >= fifo_th and fifo_th != 0.
- frame_cnt out 16: frames completed, including dropped frames.
- err out 3: sticky error bits. [0] overflow (frame dropped, FIFO full); [1] timeout; [2] conv_miss (CONV edge while busy).
- busy out 1: high whenever state != IDLE.

Behaviour:
- Reset values: DXMIT_BAR=1, wr_en=0, data2pipe=0, fifo_flag=0, frame_cnt=0, err=0, busy=0, state=IDLE, shift register and bit counter cleared.
- Reset mid-frame returns to IDLE immediately. The partial frame is discarded and no write is issued.
- CONV edge detection:
  - CONV is registered; rise = CONV & ~CONV_q.
  - CONV_q resets to 1, so a CONV held high out of reset does not start a frame.
- IDLE:
  - On rise, go to REQ and set DXMIT_BAR=0 in the next cycle (registered output).
- REQ:
  - Wait for DVALID_BAR=0.
  - The first valid cycle is also the first captured bit; go to SHIFT with bit count 1.
- SHIFT:
  - Every cycle with DVALID_BAR=0 shifts DOUT into the LSB of a 2*SAMPLE_W shift register and increments the bit count.
  - Cycles with DVALID_BAR=1 are gaps: hold, no shift.
  - When the count reaches 2*SAMPLE_W, go to WRITE and set DXMIT_BAR=1 the same cycle.
- Timeout:
  - An idle counter clears on every valid bit and on entry to REQ, and counts cycles without a valid bit in REQ and SHIFT.
  - At TIMEOUT: set err[1], DXMIT_BAR=1, go to IDLE. No write, frame_cnt unchanged.
- WRITE (exactly one cycle):
  - If fifo_full=0: wr_en=1 with data2pipe valid in the same cycle.
  - If fifo_full=1: wr_en=0 and err[0] is set.
  - In both cases frame_cnt increments (wrapping 0xFFFF→0) and the state returns to IDLE.
  - Minimum latency from the DXMIT_BAR-low cycle to wr_en is 2*SAMPLE_W+1 cycles.
- Word format:
  - [63:48] frame_cnt value before the increment.
  - [47] err[0] before this frame; [46] err[1]; [45:40] 0.
  - [39:20] ch1; [19:0] ch0. Channel 0 is shifted first.
  - Samples are right-aligned and zero-extended when SAMPLE_W < 20.
- rise in any state other than IDLE sets err[2] and is ignored. It does not queue.
- A rise coinciding with the WRITE cycle also counts as conv_miss.
- err bits clear only on RST.

Decomposition:
- Shared package holds:
  - the state enum IDLE/REQ/SHIFT/WRITE;
  - word field offsets (FRM_MSB=63, FRM_LSB=48, OVF_BIT=47, TMO_BIT=46, CH1_LSB=20);
  - err bit indices.
- One sub-module, frame_shifter: the shift register and bit counter with load/clear/shift enables, exposing a done flag at 2*SAMPLE_W.

Test Plan:
- Nominal: CONV rise; chip returns 40 contiguous valid bits, ch0=0x12345, ch1=0xABCDE → wr_en for 1 cycle, data2pipe=0x0000_ABCD_E123_45, frame_cnt=1, err=0.
- Gapped stream: same samples with DVALID_BAR high for 3 cycles every 5 bits → identical word; DXMIT_BAR stays low until bit 40.
- FIFO full: fifo_full=1 during WRITE → wr_en=0, err=3'b001, frame_cnt increments. The next frame's word has bit 47=1.
- Timeout: DXMIT_BAR low with DVALID_BAR held high for 4096 cycles → err[1]=1, DXMIT_BAR=1, no write, frame_cnt unchanged.
- conv_miss and reset: a second CONV rise during SHIFT → err[2]=1, only one word written. RST asserted at bit 17 → all outputs at reset values, no write.
- Flag: fifo_th=512 with fifo_wr_cnt stepping 511→512 → fifo_flag rises one cycle later. fifo_th=0 with fifo_wr_cnt=1023 → fifo_flag=0.

Source files
------------

// File: rtl/dout_frame_capture_pkg.sv
// dout_frame_capture_pkg: shared state encoding, FIFO word field offsets and error bit indices.
package dout_frame_capture_pkg;
    typedef enum logic [1:0] {IDLE, REQ, SHIFT, WRITE} state_t;
    localparam int FRM_MSB = 63;
    localparam int FRM_LSB = 48;
    localparam int OVF_BIT = 47;
    localparam int TMO_BIT = 46;
    localparam int CH1_LSB = 20;
    localparam int ERR_OVF = 0;
    localparam int ERR_TMO = 1;
    localparam int ERR_CMS = 2;
endpackage

// File: rtl/dout_frame_capture_frame_shifter.sv
// frame_shifter: serial-to-parallel shift register and bit counter for one DOUT frame.
module frame_shifter
    import dout_frame_capture_pkg::*;
#(
    parameter int NB = 40
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic          i_shift,
    input  logic          i_bit,
    output logic [NB-1:0] o_word,
    output logic          o_done
);
    localparam int CW = $clog2(NB + 1);
    // Only NB-1 bits are stored; the final bit is taken straight from the input so the word is ready on the done cycle.
    logic [NB-2:0] r_data;
    logic [CW-1:0] r_cnt;
    assign o_word = {r_data, i_bit};
    assign o_done = i_shift && (r_cnt == CW'(NB - 1));
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_data <= (NB - 1)'(i_bit);
            r_cnt  <= CW'(1);
        end else if (i_shift) begin
            r_data <= o_word[NB-2:0];
            r_cnt  <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/dout_frame_capture.sv
// dout_frame_capture: CONV-triggered DOUT readout that packs two samples plus frame metadata
// into one 64-bit FIFO word, with FIFO fill flag and sticky error reporting.
module dout_frame_capture
    import dout_frame_capture_pkg::*;
#(
    parameter int SAMPLE_W = 20,
    parameter int NCH      = 2,
    parameter int TIMEOUT  = 4096,
    parameter int CNT_W    = 10
) (
    input  logic             SYS_CLK,
    input  logic             RST,
    input  logic             CONV,
    input  logic             DVALID_BAR,
    input  logic             DOUT,
    output logic             DXMIT_BAR,
    output logic             wr_en,
    output logic [63:0]      data2pipe,
    input  logic             fifo_full,
    input  logic [CNT_W-1:0] fifo_wr_cnt,
    input  logic [CNT_W-1:0] fifo_th,
    output logic             fifo_flag,
    output logic [15:0]      frame_cnt,
    output logic [2:0]       err,
    output logic             busy
);
    localparam int NB = NCH * SAMPLE_W;
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t          r_state;
    logic            r_conv_q;
    logic [TW-1:0]   r_idle;
    logic            w_rise;
    logic            w_valid;
    logic            w_done;
    logic [NB-1:0]   w_frame;
    logic [63:0]     w_word;
    assign w_rise  = CONV & ~r_conv_q;
    assign w_valid = ~DVALID_BAR;
    assign wr_en   = (r_state == WRITE) && !fifo_full;
    assign busy    = (r_state != IDLE);
    frame_shifter #(.NB(NB)) u_shifter (
        .i_clk  (SYS_CLK),
        .i_rst  (RST),
        .i_clr  (r_state == IDLE),
        .i_load (r_state == REQ && w_valid),
        .i_shift(r_state == SHIFT && w_valid),
        .i_bit  (DOUT),
        .o_word (w_frame),
        .o_done (w_done)
    );
    // Channel 0 arrives first, so it sits in the upper half of the shifted frame.
    always_comb begin
        w_word                          = '0;
        w_word[FRM_MSB:FRM_LSB]         = frame_cnt;
        w_word[OVF_BIT]                 = err[ERR_OVF];
        w_word[TMO_BIT]                 = err[ERR_TMO];
        w_word[CH1_LSB +: SAMPLE_W]     = w_frame[SAMPLE_W-1:0];
        w_word[0 +: SAMPLE_W]           = w_frame[NB-1 -: SAMPLE_W];
    end
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_conv_q  <= 1'b1;
            r_idle    <= '0;
            DXMIT_BAR <= 1'b1;
            data2pipe <= '0;
            fifo_flag <= 1'b0;
            frame_cnt <= '0;
            err       <= '0;
        end else begin
            r_conv_q  <= CONV;
            fifo_flag <= (fifo_th != '0) && (fifo_wr_cnt >= fifo_th);
            if (w_rise && r_state != IDLE) err[ERR_CMS] <= 1'b1;
            case (r_state)
                IDLE: if (w_rise) begin
                    r_state   <= REQ;
                    DXMIT_BAR <= 1'b0;
                    r_idle    <= '0;
                end
                REQ, SHIFT: if (w_valid) begin
                    r_idle <= '0;
                    if (w_done) begin
                        r_state   <= WRITE;
                        DXMIT_BAR <= 1'b1;
                        data2pipe <= w_word;
                    end else begin
                        r_state <= SHIFT;
                    end
                end else if (r_idle == TW'(TIMEOUT - 1)) begin
                    err[ERR_TMO] <= 1'b1;
                    DXMIT_BAR    <= 1'b1;
                    r_state      <= IDLE;
                end else begin
                    r_idle <= r_idle + 1'b1;
                end
                WRITE: begin
                    frame_cnt <= frame_cnt + 16'd1;
                    if (fifo_full) err[ERR_OVF] <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dout_frame_capture.sv
// tb_dout_frame_capture: table-driven frame vectors plus directed timeout, reset and fill-flag sequences.
`timescale 1ns/1ps
module tb_dout_frame_capture;
    logic        SYS_CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CONV = 1'b1;
    logic        DVALID_BAR = 1'b1;
    logic        DOUT = 1'b0;
    logic        fifo_full = 1'b0;
    logic [9:0]  fifo_wr_cnt = '0;
    logic [9:0]  fifo_th = '0;
    logic        DXMIT_BAR;
    logic        wr_en;
    logic [63:0] data2pipe;
    logic        fifo_flag;
    logic [15:0] frame_cnt;
    logic [2:0]  err;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;
    int wr_pulses = 0;

    dout_frame_capture dut (
        .SYS_CLK    (SYS_CLK),
        .RST        (RST),
        .CONV       (CONV),
        .DVALID_BAR (DVALID_BAR),
        .DOUT       (DOUT),
        .DXMIT_BAR  (DXMIT_BAR),
        .wr_en      (wr_en),
        .data2pipe  (data2pipe),
        .fifo_full  (fifo_full),
        .fifo_wr_cnt(fifo_wr_cnt),
        .fifo_th    (fifo_th),
        .fifo_flag  (fifo_flag),
        .frame_cnt  (frame_cnt),
        .err        (err),
        .busy       (busy)
    );

    always #50 SYS_CLK = ~SYS_CLK;
    always @(negedge SYS_CLK) if (wr_en) wr_pulses++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [19:0] ch0;
        logic [19:0] ch1;
        int          gap;
        int          miss;
        bit          full;
        int          exp_wr;
        logic [63:0] word;
        logic [15:0] fcnt;
        logic [2:0]  err;
    } vec_t;
    vec_t tv[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_frame(input string name);
        int w = 0;
        @(negedge SYS_CLK) CONV = 1'b1;
        @(negedge SYS_CLK) CONV = 1'b0;
        while (DXMIT_BAR && w < 8) begin
            @(negedge SYS_CLK);
            w++;
        end
        chk({name, "_dxmit_low"}, DXMIT_BAR, 0);
    endtask

    task automatic run_frame(input vec_t v, input string name, output int wrs, output logic [63:0] word);
        logic [39:0] bits;
        int          wrs0;
        int          gap_hi = 0;
        bits = {v.ch0, v.ch1};
        word = '0;
        wrs0 = wr_pulses;
        fifo_full = v.full;
        start_frame(name);
        for (int i = 0; i < 40; i++) begin
            if (v.gap != 0 && i > 0 && i % 5 == 0) begin
                for (int g = 0; g < 3; g++) begin
                    DVALID_BAR = 1'b1;
                    @(negedge SYS_CLK);
                    if (DXMIT_BAR) gap_hi++;
                end
            end
            DVALID_BAR = 1'b0;
            DOUT = bits[39-i];
            CONV = (i == v.miss);
            @(negedge SYS_CLK);
            if (i < 39 && DXMIT_BAR) gap_hi++;
        end
        DVALID_BAR = 1'b1;
        CONV = 1'b0;
        chk({name, "_dxmit_early"}, gap_hi, 0);
        chk({name, "_dxmit_write"}, DXMIT_BAR, 1);
        if (wr_en) word = data2pipe;
        repeat (3) @(negedge SYS_CLK);
        fifo_full = 1'b0;
        wrs = wr_pulses - wrs0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        int          wrs;
        logic [63:0] word;
        string       nm;
        nm = $sformatf("v%0d", idx);
        run_frame(v, nm, wrs, word);
        chk({nm, "_wr"}, wrs, v.exp_wr);
        if (v.exp_wr == 1) chk({nm, "_word"}, word, v.word);
        chk({nm, "_fcnt"}, frame_cnt, v.fcnt);
        chk({nm, "_err"}, err, v.err);
        chk({nm, "_busy"}, busy, 0);
    endtask

    initial begin
        int wrs0;
        tv[0] = '{20'h12345, 20'hABCDE, 0, -1, 1'b0, 1, 64'h0000_00AB_CDE1_2345, 16'd1, 3'b000};
        tv[1] = '{20'h12345, 20'hABCDE, 1, -1, 1'b0, 1, 64'h0001_00AB_CDE1_2345, 16'd2, 3'b000};
        tv[2] = '{20'hFFFFF, 20'h00001, 0, -1, 1'b1, 0, 64'h0,                   16'd3, 3'b001};
        tv[3] = '{20'h00000, 20'hFFFFF, 0, -1, 1'b0, 1, 64'h0003_80FF_FFF0_0000, 16'd4, 3'b001};
        tv[4] = '{20'hA5A5A, 20'h5A5A5, 1, -1, 1'b0, 1, 64'h0004_805A_5A5A_5A5A, 16'd5, 3'b001};
        tv[5] = '{20'h12345, 20'hABCDE, 0, 10, 1'b0, 1, 64'h0005_80AB_CDE1_2345, 16'd6, 3'b101};

        repeat (3) @(negedge SYS_CLK);
        chk("rst_dxmit", DXMIT_BAR, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_data", data2pipe, 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flag", fifo_flag, 0);
        RST = 1'b0;
        repeat (5) @(negedge SYS_CLK);
        chk("conv_high_no_start", busy, 0);
        CONV = 1'b0;
        @(negedge SYS_CLK);

        for (int k = 0; k < 6; k++) apply(tv[k], k);

        wrs0 = wr_pulses;
        start_frame("tmo");
        repeat (4095) @(negedge SYS_CLK);
        chk("tmo_busy_before", busy, 1);
        chk("tmo_dxmit_before", DXMIT_BAR, 0);
        @(negedge SYS_CLK);
        chk("tmo_busy_after", busy, 0);
        chk("tmo_dxmit_after", DXMIT_BAR, 1);
        chk("tmo_err", err, 3'b111);
        chk("tmo_fcnt", frame_cnt, 6);
        chk("tmo_wr", wr_pulses - wrs0, 0);

        start_frame("rstmid");
        for (int i = 0; i < 17; i++) begin
            DVALID_BAR = 1'b0;
            DOUT = 1'($urandom_range(0, 1));
            @(negedge SYS_CLK);
        end
        RST = 1'b1;
        #1;
        chk("rstmid_dxmit", DXMIT_BAR, 1);
        chk("rstmid_wr_en", wr_en, 0);
        chk("rstmid_data", data2pipe, 0);
        chk("rstmid_fcnt", frame_cnt, 0);
        chk("rstmid_err", err, 0);
        chk("rstmid_busy", busy, 0);
        wrs0 = wr_pulses;
        @(negedge SYS_CLK) RST = 1'b0;
        for (int i = 0; i < 45; i++) begin
            DOUT = 1'($urandom_range(0, 1));
            @(negedge SYS_CLK);
        end
        DVALID_BAR = 1'b1;
        chk("rstmid_no_wr", wr_pulses - wrs0, 0);
        chk("rstmid_idle", busy, 0);
        apply(tv[0], 6);

        fifo_th = 10'd512;
        fifo_wr_cnt = 10'd511;
        @(negedge SYS_CLK);
        chk("flag_511", fifo_flag, 0);
        fifo_wr_cnt = 10'd512;
        #1;
        chk("flag_512_same_cycle", fifo_flag, 0);
        @(negedge SYS_CLK);
        chk("flag_512", fifo_flag, 1);
        fifo_th = 10'd0;
        fifo_wr_cnt = 10'd1023;
        @(negedge SYS_CLK);
        chk("flag_th0", fifo_flag, 0);
        fifo_th = 10'd1023;
        @(negedge SYS_CLK);
        chk("flag_1023", fifo_flag, 1);
        fifo_wr_cnt = 10'd1022;
        @(negedge SYS_CLK);
        chk("flag_1022", fifo_flag, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
